dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data SRAM between two requesters: the pipeline MEM stage and the external host port (the addr_ext_2/wen_ext_2/ren_ext_2 path).
- The CPU has default priority. A starvation guard gives the host a guaranteed slot after a bounded run of CPU grants.
- The block produces a stall to the pipeline when the CPU is refused, and routes 1-cycle-latency read data back to the requester that issued the read.
- It sits between the cpu top level and the data sram instance.

Parameters:
- ADDR_W, 10, word-address width of the data SRAM.
- DATA_W, 32, data word width.
- STARVE_LIMIT, 4, consecutive conflicting CPU grants allowed before the host wins. 0 means the host always wins a conflict.

Ports:
- clk  in  1  main clock.
- arst_n  in  1  reset, synchronous, active-low (sampled on rising clk edge only).
- cpu_req  in  1  MEM-stage access request.
- cpu_wen  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU access issued this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes the pipeline.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- ext_req  in  1  host access request; held until granted.
- ext_wen  in  1  1=write, 0=read.
- ext_addr  in  ADDR_W  host address.
- ext_wdata  in  DATA_W  host write data.
- ext_gnt  out  1  host access issued this cycle.
- ext_rvalid  out  1  host read data valid.
- ext_rdata  out  DATA_W  host read data.
- mem_en  out  1  SRAM access strobe.
- mem_wen  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after a read strobe.

Behaviour:
- Grants are combinational from the current requests and starve_cnt. At most one grant is asserted per cycle.
- Only cpu_req: cpu_gnt=1.
- Only ext_req: ext_gnt=1.
- Both requests: ext_gnt=1 iff starve_cnt==STARVE_LIMIT, otherwise cpu_gnt=1.
- No request: no grant, mem_en=0.
- SRAM side:
  - mem_en = cpu_gnt|ext_gnt.
  - mem_wen, mem_addr and mem_wdata are muxed from the granted requester.
  - When nothing is granted they are 0.
- starve_cnt (width sized for 0..STARVE_LIMIT) is registered, reset value 0:
  - +1 when ext_req & cpu_gnt, saturating at STARVE_LIMIT.
  - Cleared to 0 on ext_gnt or ~ext_req.
- Read return pipeline:
  - The registers rd_pend and rd_owner (0=CPU, 1=EXT) capture (mem_en & ~mem_wen, owner) each cycle.
  - Next cycle: cpu_rvalid = rd_pend & ~rd_owner; ext_rvalid = rd_pend & rd_owner.
  - cpu_rdata and ext_rdata both carry mem_rdata; only the rvalid signals qualify them.
- Back-to-back reads from either requester are fully pipelined: one access per cycle, one return per cycle.
- Writes complete at the grant edge and produce no rvalid.
- Reset values:
  - rd_pend=0, rd_owner=0, starve_cnt=0.
  - Hence cpu_rvalid=ext_rvalid=0 in the cycle after reset.
  - Combinational outputs follow their inputs.
- Reset mid-operation: an in-flight read return is discarded (no rvalid is issued), and the starvation history is lost.
- A request dropped without a grant is legal for the CPU (a flushed instruction) and has no side effects.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, adds two outputs:
  - conflict_cnt [31:0]: counts cycles with cpu_req & ext_req.
  - stall_cnt [31:0]: counts cycles with cpu_stall.
- Both counters are synchronous reset to 0 and wrap modulo 2^32.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - Owner encoding constants OWNER_CPU=1'b0 and OWNER_EXT=1'b1.
  - A starve counter width function clog2(STARVE_LIMIT+1), minimum 1.
- One natural sub-module: dmem_arb_starve_ctr, the saturating counter with clear.
- Grant logic and the return pipeline stay in the top module.

Test Plan:
- CPU-only reads at addresses 3, 4, 5 on consecutive cycles -> cpu_gnt=1 each cycle, cpu_rvalid=1 on the three following cycles with mem_rdata, cpu_stall=0 throughout.
- Host-only write 0xDEADBEEF to address 7, then a host read of address 7 -> ext_gnt both cycles, ext_rvalid=1 with 0xDEADBEEF one cycle after the read grant.
- Both requesting continuously, STARVE_LIMIT=4 -> pattern of 4 cpu_gnt then 1 ext_gnt (cpu_stall=1 in that cycle), then starve_cnt clears.
- STARVE_LIMIT=0 with a simultaneous request -> ext_gnt=1, cpu_stall=1, then cpu_gnt on the next cycle once ext_req drops.
- CPU read granted, arst_n=0 sampled on the next edge -> cpu_rvalid stays 0 and starve_cnt=0 after reset.
- With DMEM_ARB_STATS_EN, 10 conflict cycles at STARVE_LIMIT=4 -> conflict_cnt=10 and stall_cnt=2.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-SRAM arbiter: read-owner encoding and
// the sizing helper for the starvation counter.
package dmem_arb_pkg;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_EXT = 1'b1;

  // Bits needed to hold 0..limit; a limit of 0 still gets a 1-bit counter.
  function automatic int starve_w(input int limit);
    int w;
    w = 0;
    while ((1 << w) < (limit + 1)) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the data SRAM.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              cpu_req;
  logic              cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ext_req;
  logic              ext_wen;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  logic              mem_en;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_wen, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_en, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output ext_req, ext_wen, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_en, mem_wen, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating up-counter with synchronous clear, tracking how many conflicting
// cycles the host has lost in a row.
module dmem_arb_starve_ctr #(
  parameter int LIMIT = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data SRAM arbiter: CPU priority with a host starvation guard,
// pipeline stall and 1-cycle read return routing. Optional DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0] conflict_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam int CW = starve_w(STARVE_LIMIT);

  logic [CW-1:0]     w_starve_cnt;
  logic              w_ext_wins;
  logic              w_cpu_gnt;
  logic              w_ext_gnt;
  logic              w_cpu_stall;
  logic              w_mem_en;
  logic              w_mem_wen;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  logic              r_rd_pend;
  logic              r_rd_owner;

  dmem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .W     (CW)
  ) u_starve_ctr (
    .clk    (clk),
    .arst_n (arst_n),
    .i_inc  (bus.ext_req & w_cpu_gnt),
    .i_clr  (w_ext_gnt | ~bus.ext_req),
    .o_cnt  (w_starve_cnt)
  );

  assign w_ext_wins = (w_starve_cnt == CW'(STARVE_LIMIT));

  // The host takes a conflict only once the CPU has used up its run.
  always_comb begin
    w_ext_gnt   = bus.ext_req & (~bus.cpu_req | w_ext_wins);
    w_cpu_gnt   = bus.cpu_req & ~w_ext_gnt;
    w_cpu_stall = bus.cpu_req & ~w_cpu_gnt;
  end

  always_comb begin
    w_mem_en    = w_cpu_gnt | w_ext_gnt;
    w_mem_wen   = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    if (w_cpu_gnt) begin
      w_mem_wen   = bus.cpu_wen;
      w_mem_addr  = bus.cpu_addr;
      w_mem_wdata = bus.cpu_wdata;
    end else if (w_ext_gnt) begin
      w_mem_wen   = bus.ext_wen;
      w_mem_addr  = bus.ext_addr;
      w_mem_wdata = bus.ext_wdata;
    end
  end

  // Remember who issued this cycle's read so the returning word is routed back.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= OWNER_CPU;
    end else begin
      r_rd_pend  <= w_mem_en & ~w_mem_wen;
      r_rd_owner <= w_ext_gnt ? OWNER_EXT : OWNER_CPU;
    end
  end

  assign bus.cpu_gnt    = w_cpu_gnt;
  assign bus.ext_gnt    = w_ext_gnt;
  assign bus.cpu_stall  = w_cpu_stall;
  assign bus.mem_en     = w_mem_en;
  assign bus.mem_wen    = w_mem_wen;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.cpu_rvalid = r_rd_pend & (r_rd_owner == OWNER_CPU);
  assign bus.ext_rvalid = r_rd_pend & (r_rd_owner == OWNER_EXT);
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.ext_rdata  = bus.mem_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_conflict_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_conflict_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (bus.cpu_req & bus.ext_req) begin
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
      if (w_cpu_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign stall_cnt    = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grant/stall/mux checks each cycle and a
// read-return scoreboard fed from the bench's own memory image.
module tb_dmem_arbiter;

  logic clk;
  logic arst_n;

  int vectors;
  int miscompares;

  dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus_a ();
  dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus_b ();

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] conflict_a, stall_a, conflict_b, stall_b;
`endif

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(4)) dut_a (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus_a)
`ifdef DMEM_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_a),
    .stall_cnt    (stall_a)
`endif
  );

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(0)) dut_b (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus_b)
`ifdef DMEM_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_b),
    .stall_cnt    (stall_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int a);
    return 32'hA000_0000 | (a * 32'h0000_0101);
  endfunction

  // SRAM model behind dut_a; bit 32 marks a word that has been written.
  bit [32:0] sram_a [1024];
  always @(posedge clk) begin
    if (bus_a.mem_en) begin
      if (bus_a.mem_wen) begin
        sram_a[bus_a.mem_addr] <= {1'b1, bus_a.mem_wdata};
      end else begin
        bus_a.mem_rdata <= sram_a[bus_a.mem_addr][32] ? sram_a[bus_a.mem_addr][31:0]
                                                     : init_word(int'(bus_a.mem_addr));
      end
    end
  end

  logic [31:0] ref_mem [1024];
  logic [31:0] q_cpu[$];
  logic [31:0] q_ext[$];
  bit          pend_cpu;
  bit          pend_ext;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input bit rst_n,
                        input bit creq, input bit cwen, input int caddr, input logic [31:0] cwd,
                        input bit ereq, input bit ewen, input int eaddr, input logic [31:0] ewd,
                        input bit exp_cg, input bit exp_eg);
    logic        exp_wen;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    @(negedge clk);
    arst_n          = rst_n;
    bus_a.cpu_req   = creq;
    bus_a.cpu_wen   = cwen;
    bus_a.cpu_addr  = caddr[9:0];
    bus_a.cpu_wdata = cwd;
    bus_a.ext_req   = ereq;
    bus_a.ext_wen   = ewen;
    bus_a.ext_addr  = eaddr[9:0];
    bus_a.ext_wdata = ewd;
    #1;
    check("cpu_rvalid", 32'(bus_a.cpu_rvalid), 32'(pend_cpu));
    if (pend_cpu && q_cpu.size() > 0) check("cpu_rdata", bus_a.cpu_rdata, q_cpu.pop_front());
    check("ext_rvalid", 32'(bus_a.ext_rvalid), 32'(pend_ext));
    if (pend_ext && q_ext.size() > 0) check("ext_rdata", bus_a.ext_rdata, q_ext.pop_front());
    check("cpu_gnt", 32'(bus_a.cpu_gnt), 32'(exp_cg));
    check("ext_gnt", 32'(bus_a.ext_gnt), 32'(exp_eg));
    check("cpu_stall", 32'(bus_a.cpu_stall), 32'(creq & ~exp_cg));
    check("mem_en", 32'(bus_a.mem_en), 32'(exp_cg | exp_eg));
    exp_wen  = exp_cg ? cwen : (exp_eg ? ewen : 1'b0);
    exp_addr = exp_cg ? 32'(caddr) : (exp_eg ? 32'(eaddr) : 32'd0);
    exp_wd   = exp_cg ? cwd : (exp_eg ? ewd : 32'd0);
    check("mem_wen", 32'(bus_a.mem_wen), 32'(exp_wen));
    check("mem_addr", 32'(bus_a.mem_addr), exp_addr);
    check("mem_wdata", bus_a.mem_wdata, exp_wd);
    pend_cpu = exp_cg & ~cwen & rst_n;
    pend_ext = exp_eg & ~ewen & rst_n;
    if (pend_cpu) q_cpu.push_back(ref_mem[caddr]);
    if (pend_ext) q_ext.push_back(ref_mem[eaddr]);
    if (exp_cg & cwen) ref_mem[caddr] = cwd;
    if (exp_eg & ewen) ref_mem[eaddr] = ewd;
  endtask

  task automatic idle_a(input bit rst_n);
    step_a(rst_n, 0, 0, 0, 32'd0, 0, 0, 0, 32'd0, 0, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pend_cpu    = 0;
    pend_ext    = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    arst_n = 1'b0;
    bus_a.cpu_req = 0; bus_a.cpu_wen = 0; bus_a.cpu_addr = '0; bus_a.cpu_wdata = '0;
    bus_a.ext_req = 0; bus_a.ext_wen = 0; bus_a.ext_addr = '0; bus_a.ext_wdata = '0;
    bus_b.cpu_req = 0; bus_b.cpu_wen = 0; bus_b.cpu_addr = '0; bus_b.cpu_wdata = '0;
    bus_b.ext_req = 0; bus_b.ext_wen = 0; bus_b.ext_addr = '0; bus_b.ext_wdata = '0;
    bus_b.mem_rdata = '0;
    repeat (3) @(posedge clk);

    // Reset state, then release.
    idle_a(0);
    idle_a(1);

    // CPU-only back-to-back reads at 3, 4, 5.
    step_a(1, 1, 0, 3, 32'd0, 0, 0, 0, 32'd0, 1, 0);
    step_a(1, 1, 0, 4, 32'd0, 0, 0, 0, 32'd0, 1, 0);
    step_a(1, 1, 0, 5, 32'd0, 0, 0, 0, 32'd0, 1, 0);
    idle_a(1);
    idle_a(1);

    // Host-only write then read back.
    step_a(1, 0, 0, 0, 32'd0, 1, 1, 7, 32'hDEADBEEF, 0, 1);
    step_a(1, 0, 0, 0, 32'd0, 1, 0, 7, 32'd0, 0, 1);
    idle_a(1);

    // CPU write under conflict, CPU read-back while host waits, then host read.
    step_a(1, 1, 1, 9, 32'h1234_5678, 1, 0, 7, 32'd0, 1, 0);
    step_a(1, 1, 0, 9, 32'd0, 1, 0, 7, 32'd0, 1, 0);
    step_a(1, 0, 0, 0, 32'd0, 1, 0, 7, 32'd0, 0, 1);
    idle_a(1);

    // Host back-to-back reads.
    step_a(1, 0, 0, 0, 32'd0, 1, 0, 1, 32'd0, 0, 1);
    step_a(1, 0, 0, 0, 32'd0, 1, 0, 2, 32'd0, 0, 1);
    idle_a(1);

    // Build starvation history, then reset during a granted CPU read.
    step_a(1, 1, 0, 10, 32'd0, 1, 0, 11, 32'd0, 1, 0);
    step_a(1, 1, 0, 12, 32'd0, 1, 0, 13, 32'd0, 1, 0);
    step_a(0, 1, 0, 20, 32'd0, 1, 0, 21, 32'd0, 1, 0);

    // Ten conflict cycles from a cleared history: C C C C E repeating.
    for (int k = 0; k < 10; k++) begin
      step_a(1, 1, 0, 100 + k, 32'd0, 1, 0, 200 + k, 32'd0, (k % 5) != 4, (k % 5) == 4);
    end
    idle_a(1);
`ifdef DMEM_ARB_STATS_EN
    check("conflict_cnt", conflict_a, 32'd10);
    check("stall_cnt", stall_a, 32'd2);
`endif
    idle_a(1);

    // STARVE_LIMIT=0: host wins any conflict, CPU goes once host drops.
    @(negedge clk);
    bus_b.cpu_req = 1; bus_b.cpu_wen = 0; bus_b.cpu_addr = 10'd6;
    bus_b.ext_req = 1; bus_b.ext_wen = 1; bus_b.ext_addr = 10'd5; bus_b.ext_wdata = 32'h55AA_55AA;
    #1;
    check("b_ext_gnt", 32'(bus_b.ext_gnt), 32'd1);
    check("b_cpu_gnt", 32'(bus_b.cpu_gnt), 32'd0);
    check("b_cpu_stall", 32'(bus_b.cpu_stall), 32'd1);
    check("b_mem_addr", 32'(bus_b.mem_addr), 32'd5);
    check("b_mem_wen", 32'(bus_b.mem_wen), 32'd1);
    @(negedge clk);
    bus_b.ext_req = 0;
    #1;
    check("b_cpu_gnt2", 32'(bus_b.cpu_gnt), 32'd1);
    check("b_ext_gnt2", 32'(bus_b.ext_gnt), 32'd0);
    check("b_cpu_stall2", 32'(bus_b.cpu_stall), 32'd0);
    check("b_mem_addr2", 32'(bus_b.mem_addr), 32'd6);
    @(negedge clk);
    bus_b.cpu_req = 0;
    #1;
    check("b_cpu_rvalid", 32'(bus_b.cpu_rvalid), 32'd1);
    check("b_ext_rvalid", 32'(bus_b.ext_rvalid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
